// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced 3-to-8 decoder: FSM encoding,
// one-hot helper and the blank (inactive) output pattern.
package decoder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam logic [7:0] INACTIVE_HIGH = 8'h00;
  localparam logic [7:0] INACTIVE_LOW  = 8'hFF;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

  // Blank pattern for the selected polarity: all lines off.
  function automatic logic [7:0] inactive_pattern(input bit active_low);
    return active_low ? INACTIVE_LOW : INACTIVE_HIGH;
  endfunction

endpackage

// File: rtl/decoder3to8_dataflow.sv
// Pure combinational 3-to-8 decoder built from eight AND terms,
// active-high outputs.
module decoder3to8_dataflow (
  input  logic [2:0] code,
  output logic [7:0] dec
);

  assign dec[0] = ~code[2] & ~code[1] & ~code[0];
  assign dec[1] = ~code[2] & ~code[1] &  code[0];
  assign dec[2] = ~code[2] &  code[1] & ~code[0];
  assign dec[3] = ~code[2] &  code[1] &  code[0];
  assign dec[4] =  code[2] & ~code[1] & ~code[0];
  assign dec[5] =  code[2] & ~code[1] &  code[0];
  assign dec[6] =  code[2] &  code[1] & ~code[0];
  assign dec[7] =  code[2] &  code[1] &  code[0];

endmodule

// File: rtl/decoder3to8_seq.sv
// Registered 3-to-8 decoder with valid/ready input: each accepted code is
// shown one-hot for HOLD_CYCLES clocks, blanked for GAP_CYCLES, then done.
module decoder3to8_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int ACTIVE_LOW  = 0,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] dec_out,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0]       IDLE_PAT  = inactive_pattern(ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       code_q, code_n;
  logic             done_n;
  logic             transfer;
  logic [7:0]       dec_raw, dec_n;

  assign code_ready = (state == ST_IDLE) && en && !rst;
  assign transfer   = code_valid && code_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code_q;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (transfer) begin
          state_n = ST_HOLD;
          cnt_n   = HOLD_LOAD;
          code_n  = code_in;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_n = ST_BLANK;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (!en) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == '0) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Decode the next captured code so the registered pattern appears one clock after transfer.
  decoder3to8_dataflow u_dec (
    .code (code_n),
    .dec  (dec_raw)
  );

  assign dec_n = (state_n == ST_HOLD) ? ((ACTIVE_LOW != 0) ? ~dec_raw : dec_raw) : IDLE_PAT;

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  // NOTE: the reset branch puts every output at its inactive value immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      code_q  <= 3'd0;
      dec_out <= IDLE_PAT;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      code_q  <= code_n;
      dec_out <= dec_n;
      busy    <= (state_n != ST_IDLE);
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_decoder3to8_seq.sv
// Self-checking bench: two configurations (H=4/G=1/active-high and
// H=4/G=0/active-low) compared every cycle against a timeline model.
module tb_decoder3to8_seq;

  logic       clk = 1'b0;
  logic       rst, en, code_valid;
  logic [2:0] code_in;
  logic       ready_a, busy_a, done_a, ready_b, busy_b, done_b;
  logic [7:0] dec_a, dec_b;

  always #5 clk = ~clk;

  decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .ACTIVE_LOW(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready_a), .dec_out(dec_a), .busy(busy_a), .done(done_a)
  );

  decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .ACTIVE_LOW(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .en(en), .code_in(code_in), .code_valid(code_valid),
    .code_ready(ready_b), .dec_out(dec_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: a sequence is a timeline of cycles since transfer (age 1..H shows, H+1..H+G blank).
  int mh [2] = '{4, 4};
  int mg [2] = '{1, 0};
  bit mal[2] = '{1'b0, 1'b1};
  bit m_active[2];
  int m_age[2];
  int m_code[2];
  bit m_done[2];
  bit m_xfer[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pattern(input int d, input int c, input bit show);
    logic [7:0] p;
    p = 8'h00;
    if (show) p[c[2:0]] = 1'b1;
    return mal[d] ? ~p : p;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_age[d]    = 0;
      m_done[d]   = 1'b0;
      m_xfer[d]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 1'b0;
      m_xfer[d] = 1'b0;
      if (rst) begin
        m_active[d] = 1'b0;
        m_age[d]    = 0;
      end else if (!m_active[d]) begin
        if (en && code_valid) begin
          m_active[d] = 1'b1;
          m_age[d]    = 1;
          m_code[d]   = int'(code_in);
          m_xfer[d]   = 1'b1;
        end
      end else if (!en) begin
        m_active[d] = 1'b0;
      end else begin
        m_age[d]++;
        if (m_age[d] > mh[d] + mg[d]) begin
          m_active[d] = 1'b0;
          m_done[d]   = 1'b1;
        end
      end
    end
  endtask

  task automatic compare();
    logic [7:0] act_dec;
    logic       act_busy, act_done, act_ready;
    for (int d = 0; d < 2; d++) begin
      act_dec   = (d == 0) ? dec_a   : dec_b;
      act_busy  = (d == 0) ? busy_a  : busy_b;
      act_done  = (d == 0) ? done_a  : done_b;
      act_ready = (d == 0) ? ready_a : ready_b;
      check($sformatf("dec[%0d]", d), 32'(act_dec),
            32'(pattern(d, m_code[d], m_active[d] && (m_age[d] <= mh[d]))));
      check($sformatf("busy[%0d]", d), 32'(act_busy), 32'(m_active[d]));
      check($sformatf("done[%0d]", d), 32'(act_done), 32'(m_done[d]));
      check($sformatf("ready[%0d]", d), 32'(act_ready), 32'(!m_active[d] && en && !rst));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic settle();
    for (int i = 0; i < 20 && (m_active[0] || m_active[1]); i++) step();
    check("settle_idle", 32'(m_active[0] || m_active[1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         sweep_idx, done_cnt;
    logic [7:0] last, exp8;
    logic [7:0] seen[$];
    int         xfer_t[$];
    bit         seen7;

    rst = 1'b1; en = 1'b0; code_valid = 1'b0; code_in = 3'd0;
    model_reset();
    repeat (2) step();
    check("rst_dec_a", 32'(dec_a), 32'h00);
    check("rst_dec_b", 32'(dec_b), 32'hFF);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    rst = 1'b0; en = 1'b1;

    // Single code 5 at defaults
    code_in = 3'd5; code_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      code_valid = 1'b0;
      if (i <= 4) begin
        check("t1_hold_a", 32'(dec_a), 32'h20);
        check("t1_hold_b", 32'(dec_b), 32'hDF);
        check("t1_busy_a", 32'(busy_a), 32'd1);
      end else if (i == 5) begin
        check("t1_gap_a", 32'(dec_a), 32'h00);
        check("t1_gap_busy_a", 32'(busy_a), 32'd1);
        check("t1_done_b", 32'(done_b), 32'd1);
        check("t1_blank_b", 32'(dec_b), 32'hFF);
      end else begin
        check("t1_done_a", 32'(done_a), 32'd1);
        check("t1_ready_a", 32'(ready_a), 32'd1);
        check("t1_idle_a", 32'(busy_a), 32'd0);
      end
    end

    // Sweep codes 0..7 with valid held high
    sweep_idx = 0; done_cnt = 0; last = 8'h00;
    code_in = 3'd0; code_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && done_cnt < 8; cyc++) begin
      step();
      if (cyc == 0) check("al_code0_b", 32'(dec_b), 32'hFE);
      if (m_xfer[0]) begin
        sweep_idx++;
        xfer_t.push_back(cyc);
      end
      code_in = sweep_idx[2:0];
      if (sweep_idx >= 8) code_valid = 1'b0;
      if (done_a) done_cnt++;
      if (dec_a != 8'h00 && dec_a != last) seen.push_back(dec_a);
      last = dec_a;
    end
    code_valid = 1'b0;
    check("sweep_done_cnt", 32'(done_cnt), 32'd8);
    check("sweep_len", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      exp8 = 8'h01;
      exp8 = exp8 << i;
      check($sformatf("sweep_pat%0d", i), 32'(seen[i]), 32'(exp8));
    end
    for (int i = 1; i < xfer_t.size(); i++)
      check($sformatf("sweep_period%0d", i), 32'(xfer_t[i] - xfer_t[i-1]), 32'd6);
    settle();

    // Abort with en low mid-hold
    code_in = 3'd3; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    step();
    en = 1'b0;
    step();
    check("abort_dec_a", 32'(dec_a), 32'h00);
    check("abort_busy_a", 32'(busy_a), 32'd0);
    check("abort_done_a", 32'(done_a), 32'd0);
    check("abort_dec_b", 32'(dec_b), 32'hFF);
    code_valid = 1'b1;
    repeat (3) begin
      step();
      check("abort_ready_a", 32'(ready_a), 32'd0);
      check("abort_nodone_a", 32'(done_a), 32'd0);
      check("abort_idle_a", 32'(busy_a), 32'd0);
    end
    code_valid = 1'b0; en = 1'b1;
    step();
    check("reenable_ready_a", 32'(ready_a), 32'd1);

    // Code presented while busy is ignored
    seen7 = 1'b0;
    code_in = 3'd2; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    step();
    code_in = 3'd7; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("busy_ign_t3", 32'(dec_a), 32'h04);
    step();
    check("busy_ign_t4", 32'(dec_a), 32'h04);
    repeat (8) begin
      step();
      if (dec_a == 8'h80 || dec_b == 8'h7F) seen7 = 1'b1;
    end
    check("never_shown7", 32'(seen7), 32'd0);
    settle();

    // Asynchronous reset mid-hold
    code_in = 3'd6; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    step();
    check("pre_rst_dec_a", 32'(dec_a), 32'h40);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_dec_a", 32'(dec_a), 32'h00);
    check("async_busy_a", 32'(busy_a), 32'd0);
    check("async_dec_b", 32'(dec_b), 32'hFF);
    check("async_busy_b", 32'(busy_b), 32'd0);
    check("async_ready_a", 32'(ready_a), 32'd0);
    step();
    rst = 1'b0;
    code_in = 3'd1; code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("post_rst_busy_a", 32'(busy_a), 32'd1);
    check("post_rst_dec_a", 32'(dec_a), 32'h02);
    settle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 15) != 0);
      code_valid = $urandom_range(0, 1) == 1;
      code_in    = 3'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder3to8_seq.md
Name: decoder3to8_seq

Overview:
Registered 3-to-8 one-hot decoder with a valid/ready code input, driving 8 LEDs (or anode/enable lines) on the Basys3 board. Each accepted 3-bit code is shown as one-hot for HOLD_CYCLES clocks, then blanked for GAP_CYCLES clocks, then the block signals done and accepts the next code. It is the decode-side counterpart of the team's 8-to-3 encoders and is used for LED chase/readback demos and digit-select sequencing.

Parameters:
HOLD_CYCLES, 4, clocks the one-hot pattern is driven per accepted code; must be >= 1
GAP_CYCLES, 1, blank clocks after each hold; 0 allowed (no blank phase)
ACTIVE_LOW, 0, 1 = dec_out inverted (active line low, inactive lines high)
CNT_W, 16, counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  block enable; low blocks acceptance and aborts a sequence in progress
code_in  input  3  binary code to decode
code_valid  input  1  code_in is valid
code_ready  output  1  block can accept a code this cycle
dec_out  output  8  one-hot decoded output; bit N active when code N is shown
busy  output  1  high in HOLD or BLANK
done  output  1  one-cycle pulse when a sequence completes normally

Behaviour:
- One clock; reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
- Reset value: state IDLE, counter 0, captured code 0. dec_out is inactive: 8'h00, or 8'hFF when ACTIVE_LOW=1. busy=0, done=0.
- code_ready = (state==IDLE) && en && !rst. It is combinational from state/en.
- Handshake: a transfer occurs at a rising edge where code_valid && code_ready. code_in is captured on that edge. code_valid is ignored at all other times; a code presented while busy is neither captured nor queued.
- FSM states: IDLE, HOLD, BLANK.
  - IDLE -> HOLD on transfer; counter loads HOLD_CYCLES-1.
  - HOLD: dec_out = onehot(captured code), polarity per ACTIVE_LOW. Counter decrements each clock.
  - HOLD -> BLANK when counter==0 and GAP_CYCLES>0; counter loads GAP_CYCLES-1.
  - HOLD -> IDLE when counter==0 and GAP_CYCLES==0.
  - BLANK: dec_out inactive, counter decrements. BLANK -> IDLE when counter==0.
- Timing, with the transfer on edge T:
  - Cycles T+1..T+H show the pattern.
  - Cycles T+H+1..T+H+G are blank.
  - Cycle T+H+G+1 is IDLE with done=1 and code_ready=1 (if en).
  - Latency from transfer to pattern is 1 clock. dec_out, busy and done are all registered.
- Back-to-back: if code_valid is held high, the next transfer occurs on the first IDLE edge. The code period is H+G+1 clocks.
- done: registered, high exactly one cycle, on the first IDLE cycle after a normal completion only.
- Abort: en low while sampled at an edge in HOLD or BLANK -> the next cycle is IDLE with dec_out inactive, busy=0, and no done pulse.
- Reset mid-operation: outputs go to reset values immediately (asynchronous). After rst falls, the first transfer can occur on the first edge.
- Every 3-bit code is legal; there is no invalid-input case. Exactly one line is active in HOLD, and zero lines are active otherwise.

Decomposition:
- Shared package/include decoder_pkg:
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, BLANK=2'd2.
  - Function onehot8(code) returning 8'b1 << code.
  - Inactive-pattern constant, selected by ACTIVE_LOW.
- One natural sub-module: decoder3to8_dataflow, a pure combinational 3-to-8 decoder with 8 AND terms. It is instantiated on the captured code; its output is muxed against the inactive pattern, polarity-adjusted and registered in the parent.

Test Plan:
- Defaults (H=4, G=1): rst pulse, then code_in=3'd5 with code_valid=1 at edge T -> dec_out=8'b0010_0000 in T+1..T+4, 8'h00 at T+5, done=1 and code_ready=1 at T+6, busy=1 in T+1..T+5.
- Sweep: code_valid held high with codes 0..7 presented on each transfer -> dec_out steps 8'h01,02,04,...,80. Each code is held 4 cycles with a 6-cycle period and 8 done pulses.
- ACTIVE_LOW=1, GAP_CYCLES=0: code 0 -> dec_out=8'hFE for 4 cycles, then 8'hFF with done in the next cycle. Reset value is 8'hFF.
- Abort: code 3 accepted at T, en=0 at edge T+2 -> dec_out=8'h00 and busy=0 at T+3, no done, code_ready=0 until en=1.
- Ignore-while-busy: code 7 with valid pulsed at T+2 during a code-2 hold -> dec_out stays 8'h04, and 7 is never shown.
- Async reset: rst asserted mid-HOLD between edges -> dec_out=8'h00 and busy=0 without waiting for clk. A transfer on the first edge after release is accepted.
